// File: rtl/alu_md_unit.sv
// alu_md_unit: execute-stage arithmetic unit covering the RV32I ALU operations
// and the RV32M multiply/divide/remainder operations at XLEN bits.
//
// Ports:
//   clk, rst           clock and asynchronous active-low reset
//   in_valid/in_ready  operation request handshake (in_ready is combinational)
//   op, a, b           operation code and operands
//   flush              synchronous kill of the in-flight or pending operation
//   out_valid/ready    result handshake
//   result             registered result
//   zero, negative     registered flags for result == 0 and result MSB
//   overflow           registered signed overflow for add/sub
//   busy               divider iteration in progress
//
// ALU ops, multiplies and divide special cases load their result at the
// accepting edge. A normal divide runs a radix-2 restoring divider on the
// operand magnitudes for XLEN cycles. The last quotient bit and the sign
// fix-up are folded into the edge that loads the result.
module alu_md_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            negative,
    output logic            overflow,
    output logic            busy
);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic accept;
    logic load_quick, load_div, start_div;

    // Single-cycle datapath
    logic [XLEN-1:0]   sum, dif;
    logic [SHW-1:0]    shamt;
    logic              a_sgn, b_sgn;
    logic [2*XLEN-1:0] ext_a, ext_b, prod;
    logic              div_sgn, div_rem, div_long;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   quick_res;
    logic              quick_ovf, quick_ok;

    // Divider state
    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic [SHW-1:0]  cnt_q;
    logic            neg_q_q, neg_r_q, rem_sel_q;
    logic [XLEN:0]   shifted, diff;
    logic            take;
    logic [XLEN-1:0] rem_nx, quo_nx, div_res;

    assign sum   = a + b;
    assign dif   = a - b;
    assign shamt = b[SHW-1:0];

    // mul/mulh/mulhsu treat a as signed, mul/mulh treat b as signed; the low
    // half used by mul is the same either way.
    assign a_sgn = (op[1:0] != 2'b11);
    assign b_sgn = (op[1] == 1'b0);
    assign ext_a = {{XLEN{a_sgn & a[XLEN-1]}}, a};
    assign ext_b = {{XLEN{b_sgn & b[XLEN-1]}}, b};
    assign prod  = ext_a * ext_b;

    assign div_sgn = ~op[0];
    assign div_rem = op[1];
    assign mag_a   = (div_sgn & a[XLEN-1]) ? (~a + 1'b1) : a;
    assign mag_b   = (div_sgn & b[XLEN-1]) ? (~b + 1'b1) : b;

    always_comb begin
        quick_res = '0;
        quick_ovf = 1'b0;
        quick_ok  = 1'b1;
        div_long  = 1'b0;
        case (op)
            5'b00000: begin
                quick_res = sum;
                quick_ovf = (a[XLEN-1] == b[XLEN-1]) & (sum[XLEN-1] != a[XLEN-1]);
            end
            5'b00001: begin
                quick_res = dif;
                // subtrahend's effective sign is inverted
                quick_ovf = (a[XLEN-1] != b[XLEN-1]) & (dif[XLEN-1] != a[XLEN-1]);
            end
            5'b00010: quick_res = a & b;
            5'b00011: quick_res = a | b;
            5'b00100: quick_res = a << shamt;
            5'b00101: quick_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            5'b00110: quick_res = a ^ b;
            5'b00111: quick_res = a >> shamt;
            5'b01000: quick_res = {{(XLEN-1){1'b0}}, (a < b)};
            5'b01111: quick_res = $signed(a) >>> shamt;
            5'b10000: quick_res = prod[XLEN-1:0];
            5'b10001,
            5'b10010,
            5'b10011: quick_res = prod[2*XLEN-1:XLEN];
            5'b10100,
            5'b10101,
            5'b10110,
            5'b10111: begin
                if (b == '0) begin
                    quick_res = div_rem ? a : '1;
                end else if (div_sgn && (a == MIN_VAL) && (b == '1)) begin
                    quick_res = div_rem ? '0 : a;
                end else begin
                    div_long = 1'b1;
                end
            end
            default: quick_ok = 1'b0;
        endcase
    end

    // Restoring step: the partial remainder is always below the divisor, so
    // the shifted value needs one extra bit and the difference fits when taken.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign take    = ~diff[XLEN];
    assign rem_nx  = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_nx  = {quo_q[XLEN-2:0], take};

    always_comb begin
        div_res = quo_nx;
        if (rem_sel_q) begin
            div_res = neg_r_q ? (~rem_nx + 1'b1) : rem_nx;
        end else if (neg_q_q) begin
            div_res = ~quo_nx + 1'b1;
        end
    end

    assign in_ready  = rst & ~flush &
                       ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_DIV);

    always_comb begin
        state_d    = state_q;
        load_quick = 1'b0;
        load_div   = 1'b0;
        start_div  = 1'b0;
        case (state_q)
            S_DIV: begin
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    load_div = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase
        // accept is only possible from IDLE or a consumed DONE
        if (accept) begin
            if (div_long) begin
                state_d   = S_DIV;
                start_div = 1'b1;
            end else begin
                state_d    = S_DONE;
                load_quick = 1'b1;
            end
        end
        if (flush) begin
            state_d  = S_IDLE;
            load_div = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result   <= '0;
            zero     <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else if (load_quick) begin
            result   <= quick_res;
            zero     <= quick_ok & (quick_res == '0);
            negative <= quick_ok & quick_res[XLEN-1];
            overflow <= quick_ovf;
        end else if (load_div) begin
            result   <= div_res;
            zero     <= (div_res == '0);
            negative <= div_res[XLEN-1];
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            rem_sel_q <= 1'b0;
        end else if (start_div) begin
            rem_q     <= '0;
            quo_q     <= mag_a;
            dvs_q     <= mag_b;
            cnt_q     <= SHW'(XLEN - 1);
            neg_q_q   <= div_sgn & (a[XLEN-1] ^ b[XLEN-1]);
            neg_r_q   <= div_sgn & a[XLEN-1];
            rem_sel_q <= div_rem;
        end else if (state_q == S_DIV) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_md_unit.sv
// Self-checking bench for alu_md_unit (XLEN = 32): directed vector table,
// hand-written handshake/flush/reset sequences, and random operations
// compared with an arithmetic reference model.
module tb_alu_md_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero, negative, overflow, busy;

    int checks = 0;
    int errors = 0;

    alu_md_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        n;
        logic        v;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic addv(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] r, input logic z, input logic n, input logic v,
                        input int lat);
        vec_t e;
        e.op = o; e.a = x; e.b = y; e.res = r; e.z = z; e.n = n; e.v = v; e.lat = lat;
        vecs.push_back(e);
    endtask

    // Reference model from the arithmetic definitions of each operation.
    function automatic void model(input logic [4:0] o, input logic [31:0] x,
                                  input logic [31:0] y, output logic [31:0] r,
                                  output logic ov, output logic ok, output int lat);
        longint sx, sy, s;
        longint unsigned ux, uy;
        logic [63:0] p;
        int ix, iy, q;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        ix = x;
        iy = y;
        r = '0; ov = 1'b0; ok = 1'b1; lat = 1; s = 0; p = '0; q = 0;
        case (o)
            5'd0:  begin s = sx + sy; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            5'd1:  begin s = sx - sy; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            5'd2:  r = x & y;
            5'd3:  r = x | y;
            5'd4:  r = x << y[4:0];
            5'd5:  r = (sx < sy) ? 32'd1 : 32'd0;
            5'd6:  r = x ^ y;
            5'd7:  r = x >> y[4:0];
            5'd8:  r = (ux < uy) ? 32'd1 : 32'd0;
            5'd15: r = $signed(x) >>> y[4:0];
            5'd16: begin s = sx * sy; r = s[31:0]; end
            5'd17: begin s = sx * sy; r = s[63:32]; end
            5'd18: begin s = sx * longint'(uy); r = s[63:32]; end
            5'd19: begin p = ux * uy; r = p[63:32]; end
            5'd20: begin
                if (y == 0) r = 32'hFFFFFFFF;
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = x;
                else begin q = ix / iy; r = q; lat = 33; end
            end
            5'd21: begin
                if (y == 0) r = 32'hFFFFFFFF;
                else begin r = x / y; lat = 33; end
            end
            5'd22: begin
                if (y == 0) r = x;
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 0;
                else begin q = ix % iy; r = q; lat = 33; end
            end
            5'd23: begin
                if (y == 0) r = x;
                else begin r = x % y; lat = 33; end
            end
            default: ok = 1'b0;
        endcase
    endfunction

    // Issue one operation with out_ready high and check everything it returns.
    task automatic run_op(input string name, input logic [4:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] er, input logic ez,
                          input logic en, input logic ev, input int elat);
        int w, lat, bcyc, viol;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_accept"}, (w < 50) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1; bcyc = 0; viol = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bcyc++;
            if (busy && in_ready) viol++;
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"}, lat, elat);
        chk({name, "_busy"}, bcyc, (elat == 33) ? 32 : 0);
        chk({name, "_rdy"}, viol, 0);
        chk({name, "_res"}, result, er);
        chk({name, "_flags"}, {zero, negative, overflow}, {ez, en, ev});
    endtask

    function automatic logic [31:0] pick_operand();
        int k;
        k = $urandom_range(0, 7);
        case (k)
            0: return 32'h00000000;
            1: return 32'h00000001;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0]  ops[20];
        logic [4:0]  bo[4];
        logic [31:0] ba[4], bb[4], be[4];
        logic [31:0] r;
        logic        ov, ok;
        int          lat, w, cnt;

        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd15,
                5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd9, 5'd24};

        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outs", {31'd0, out_valid, busy, zero, negative, overflow, in_ready}, 0);
        chk("rst_result", result, 0);
        rst = 1'b1;
        #1;
        chk("rst_ready", {31'd0, in_ready}, 1);

        // Directed vector table
        addv(5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 1, 1);
        addv(5'b00001, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0, 0, 1);
        addv(5'b00001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 0, 1, 1);
        addv(5'b00010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 0, 1);
        addv(5'b00011, 32'hF0000000, 32'h0000000F, 32'hF000000F, 0, 1, 0, 1);
        addv(5'b00110, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 1, 0, 0, 1);
        addv(5'b00111, 32'h80000000, 32'h0000001F, 32'h00000001, 0, 0, 0, 1);
        addv(5'b10001, 32'h80000000, 32'h80000000, 32'h40000000, 0, 0, 0, 1);
        addv(5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1, 0, 1);
        addv(5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 0, 1);
        addv(5'b10000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 0, 1, 0, 1);
        addv(5'b10100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 0, 1, 0, 33);
        addv(5'b10110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 0, 1, 0, 33);
        addv(5'b10101, 32'd100,      32'd7,        32'd14,       0, 0, 0, 33);
        addv(5'b10111, 32'd100,      32'd7,        32'd2,        0, 0, 0, 33);
        addv(5'b10100, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 1, 0, 1);
        addv(5'b10110, 32'd5,        32'd0,        32'd5,        0, 0, 0, 1);
        addv(5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1, 0, 1);
        addv(5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0, 1);
        addv(5'b01001, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 0, 1);
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].v, vecs[i].lat);
        end

        // Back-to-back single-cycle ops, one result per cycle
        bo[0] = 5'b00100; ba[0] = 32'h00000001; bb[0] = 32'h00000023; be[0] = 32'h00000008;
        bo[1] = 5'b01111; ba[1] = 32'h80000000; bb[1] = 32'h00000004; be[1] = 32'hF8000000;
        bo[2] = 5'b00101; ba[2] = 32'hFFFFFFFF; bb[2] = 32'h00000001; be[2] = 32'h00000001;
        bo[3] = 5'b01000; ba[3] = 32'hFFFFFFFF; bb[3] = 32'h00000001; be[3] = 32'h00000000;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("b2b%0d_valid", i - 1), {31'd0, out_valid}, 1);
                chk($sformatf("b2b%0d_res", i - 1), result, be[i-1]);
            end
            if (i < 4) begin
                op = bo[i]; a = ba[i]; b = bb[i]; in_valid = 1'b1;
                #1;
                chk($sformatf("b2b%0d_ready", i), {31'd0, in_ready}, 1);
            end else begin
                in_valid = 1'b0;
            end
        end

        // Backpressure on a divu result
        @(negedge clk);
        op = 5'b10101; a = 32'd100; b = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("bp_wait", (w < 100) ? 32'd1 : 32'd0, 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_res", k), result, 32'd14);
            chk($sformatf("bp%0d_vr", k), {30'd0, out_valid, in_ready}, 32'b10);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {31'd0, out_valid}, 0);

        // Flush partway through a divide
        op = 5'b10100; a = 32'hFFFFFFF9; b = 32'd2; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl_ready", {30'd0, busy, in_ready}, 32'b10);
        @(negedge clk);
        flush = 1'b0;
        chk("fl_after", {30'd0, busy, out_valid}, 0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("fl_novalid", cnt, 0);
        run_op("fl_add", 5'b00000, 32'd2, 32'd3, 32'd5, 0, 0, 0, 1);

        // Random operations against the reference model
        for (int t = 0; t < 250; t++) begin
            logic [4:0]  ro;
            logic [31:0] ra, rb;
            ro = ops[$urandom_range(0, 19)];
            ra = pick_operand();
            rb = pick_operand();
            model(ro, ra, rb, r, ov, ok, lat);
            run_op($sformatf("rnd%0d_op%0d", t, ro), ro, ra, rb, r,
                   ok & (r == 0), ok & r[31], ov, lat);
        end

        // Reset asserted partway through a divide
        @(negedge clk);
        op = 5'b10110; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rm_outs", {31'd0, out_valid, busy, zero, negative, overflow, in_ready}, 0);
        chk("rm_result", result, 0);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("rm_novalid", cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_md_unit.md
# alu_md_unit

Parametrised execute-stage arithmetic unit for the 5-stage RISC-V pipeline, replacing the single-cycle ALU. It implements the RV32I ALU operations and the RV32M multiply/divide/remainder operations at a configurable data width. Operands arrive and results leave through valid/ready handshakes, so the hazard unit can stall the pipeline while an iterative divide runs. Results and flags are registered, and a flush input lets branch/jump resolution kill an in-flight operation.

## Interface
- XLEN, 32, datapath width; any value ≥ 8 and a power of two
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden)
- clk  in  1  clock; everything is updated on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; combinational
- op  in  5  operation code, see Operation
- a, b  in  XLEN  operands
- flush  in  1  synchronous kill of the in-flight/pending operation
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- zero  out  1  result == 0
- negative  out  1  result[XLEN-1]
- overflow  out  1  signed overflow for add/sub only, else 0
- busy  out  1  divide iteration in progress

## Operation
- Encoding for op[4]=0: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 slt, 00110 xor, 00111 srl, 01000 sltu, 01111 sra.
- Encoding for op[4]=1: 10000 mul, 10001 mulh, 10010 mulhsu, 10011 mulhu, 10100 div, 10101 divu, 10110 rem, 10111 remu.
- Any other op code gives result 0 with all flags 0.
- Shift operations use only b[SHW-1:0].
- slt/sltu produce the zero-extended value 1 or 0. slt = (a <s b), computed correctly under overflow.
- overflow is computed for add (op 00000) and sub (op 00001) only: the operands have equal effective signs and the sum's sign differs.
- mul returns the low XLEN bits of the product. mulh, mulhsu and mulhu return the high XLEN bits of the 2·XLEN-bit product with operands signed×signed, signed×unsigned and unsigned×unsigned respectively.
- Divide by zero: div/divu return all ones; rem/remu return a.
- Signed overflow (a = −2^(XLEN−1), b = −1): div returns a; rem returns 0.
- Both divide special cases complete with single-cycle latency.
- Normal divides use a radix-2 restoring divider on the operand magnitudes, one quotient bit per cycle. Signs are fixed up at the end: the quotient is negated when the operand signs differ, and the remainder takes the sign of a.
- State machine:
  - IDLE: on accept, a single-cycle op (or divide special case) goes to DONE with its result loaded; a normal divide goes to DIV with counter = XLEN−1.
  - DIV: one step per cycle; when counter == 0, apply sign fix, load result, go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE; if a new op is accepted in the same cycle, it is processed as if from IDLE.
- in_ready = (state == IDLE) | (state == DONE & out_ready), gated low while flush = 1.
- flush = 1: go to IDLE next edge, drop any pending result (out_valid → 0), abandon the divider. Flush takes priority over in_valid and out_ready in the same cycle.
- In DONE with out_ready = 0: result and flags hold stable.

## Timing
- Reset (rst = 0, asynchronous): state IDLE, out_valid 0, result 0, zero 0, negative 0, overflow 0, busy 0, divider registers 0. in_ready is 1 once rst is released.
- ALU ops, mul*, and divide special cases: out_valid rises exactly 1 edge after the accepting edge. With out_ready held high, throughput is 1 op/cycle.
- Normal div/rem: busy is high for XLEN cycles. out_valid rises exactly XLEN+1 edges after the accepting edge (33 for XLEN=32).
- zero, negative and overflow are registered together with result and change only when result loads.
- Reset asserted mid-divide: all state clears immediately; no result is ever presented.

## Test plan
- Reset, then add a=0x7FFFFFFF, b=1 → 1 cycle later out_valid, result 0x80000000, overflow 1, negative 1; sub a=5, b=5 → result 0, zero 1.
- Back-to-back with out_ready = 1: sll a=1, b=0x23 (shift 3) → 8; sra a=0x80000000, b=4 → 0xF8000000; slt a=−1, b=1 → 1; sltu same operands → 0. One result per cycle, in order.
- mulh a=0x80000000, b=0x80000000 → 0x40000000; mulhu a=b=0xFFFFFFFF → 0xFFFFFFFE; mulhsu a=−1, b=0xFFFFFFFF → 0xFFFFFFFF; mul a=−3, b=7 → 0xFFFFFFEB.
- div a=−7, b=2 → out_valid at edge 33, result 0xFFFFFFFD, busy high for 32 cycles, in_ready 0 during busy; rem same operands → 0xFFFFFFFF; divu 100/7 → 14, remu → 2.
- Divide special cases: div 5/0 → 0xFFFFFFFF and rem 5/0 → 5, each in 1 cycle; div 0x80000000/−1 → 0x80000000 and rem → 0, each in 1 cycle.
- Backpressure and kill:
  - Hold out_ready = 0 for 5 cycles after the divu result → result stable, in_ready 0.
  - Assert flush at cycle 10 of a divide → out_valid never rises, busy 0 next cycle, the next add completes normally.
  - Assert rst mid-divide → all outputs 0 at once.
